// File: rtl/inst_fetch.sv
// ---------------------------------------------------------------------------
// inst_fetch -- instruction fetch stage with a single outstanding request.
//
// Issues one instruction-memory request at a time, buffers a returned word
// while decode is stalled, tracks a pending branch redirect for the delay
// slot, drops responses belonging to flushed requests, and reports
// misaligned fetch addresses as an address error instead of fetching.
//
// Ports
//   clk        in   1   clock, all state updates on the rising edge
//   rst        in   1   synchronous active-high reset
//   stall      in   1   decode cannot accept an instruction this cycle
//   flush      in   1   exception/eret redirect request
//   flush_pc   in   32  redirect target, valid with flush
//   br_taken   in   1   decode resolved a taken branch/jump
//   br_target  in   32  branch target, valid with br_taken
//   ireq       out  1   instruction memory request
//   iaddr      out  32  request address
//   igrant     in   1   memory accepted the request this cycle
//   ivalid     in   1   read data valid, one pulse per granted request
//   irdata     in   32  read data
//   id_inst    out  32  instruction to decode
//   id_pc      out  32  PC of id_inst
//   id_valid   out  1   id_inst/id_pc hold a real instruction
//   id_adel    out  1   fetch address error (PC not word-aligned)
// ---------------------------------------------------------------------------
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        ireq,
  output logic [31:0] iaddr,
  input  logic        igrant,
  input  logic        ivalid,
  input  logic [31:0] irdata,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic        id_valid,
  output logic        id_adel
);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DISCARD
  } state_t;

  state_t      r_state;
  state_t      w_stateNext;

  logic [31:0] r_pc;
  logic        r_brPend;
  logic [31:0] r_brPc;
  logic [31:0] r_holdData;
  logic [31:0] r_idInst;
  logic [31:0] r_idPc;
  logic        r_idValid;
  logic        r_idAdel;

  logic        w_misaligned;
  logic        w_ireq;
  logic [31:0] w_nextPc;
  logic        w_deliver;
  logic [31:0] w_deliverData;
  logic        w_adelDeliver;
  logic        w_capture;

  // Request and redirect-address decode. A branch resolving in the same
  // cycle as the delay-slot delivery must win over the registered copy.
  always_comb begin
    w_misaligned = (r_pc[1:0] != 2'b00);
    w_ireq       = (r_state == S_REQ) && !w_misaligned && !rst;
    if (br_taken) begin
      w_nextPc = br_target;
    end else if (r_brPend) begin
      w_nextPc = r_brPc;
    end else begin
      w_nextPc = r_pc + 32'd4;
    end
  end

  // Next-state logic plus the per-cycle delivery/capture strobes that the
  // datapath register block consumes.
  always_comb begin
    w_stateNext   = r_state;
    w_deliver     = 1'b0;
    w_deliverData = irdata;
    w_adelDeliver = 1'b0;
    w_capture     = 1'b0;
    case (r_state)
      S_REQ: begin
        if (flush) begin
          // A grant in the flush cycle still produces a response later.
          w_stateNext = (w_ireq && igrant) ? S_DISCARD : S_REQ;
        end else if (w_misaligned) begin
          w_adelDeliver = !stall;
        end else if (igrant) begin
          w_stateNext = S_WAIT;
        end
      end
      S_WAIT: begin
        if (flush) begin
          w_stateNext = ivalid ? S_REQ : S_DISCARD;
        end else if (ivalid) begin
          if (stall) begin
            w_capture   = 1'b1;
            w_stateNext = S_HOLD;
          end else begin
            w_deliver   = 1'b1;
            w_stateNext = S_REQ;
          end
        end
      end
      S_HOLD: begin
        if (flush) begin
          w_stateNext = S_REQ;
        end else if (!stall) begin
          w_deliver     = 1'b1;
          w_deliverData = r_holdData;
          w_stateNext   = S_REQ;
        end
      end
      S_DISCARD: begin
        // The stale response retires the outstanding request even if a
        // second flush lands in the same cycle; otherwise we never leave.
        if (ivalid) begin
          w_stateNext = S_REQ;
        end
      end
      default: w_stateNext = S_REQ;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_REQ;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // PC, branch-pending, hold buffer and decode-facing registers. Flush
  // outranks stall; a stall freezes the id_* registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc       <= RESET_PC;
      r_brPend   <= 1'b0;
      r_brPc     <= 32'd0;
      r_holdData <= 32'd0;
      r_idInst   <= 32'd0;
      r_idPc     <= 32'd0;
      r_idValid  <= 1'b0;
      r_idAdel   <= 1'b0;
    end else if (flush) begin
      r_pc      <= flush_pc;
      r_brPend  <= 1'b0;
      r_idValid <= 1'b0;
      r_idInst  <= 32'd0;
      r_idAdel  <= 1'b0;
    end else begin
      if (w_capture) begin
        r_holdData <= irdata;
      end
      if (w_deliver) begin
        r_idInst  <= w_deliverData;
        r_idPc    <= r_pc;
        r_idValid <= 1'b1;
        r_idAdel  <= 1'b0;
        r_pc      <= w_nextPc;
        r_brPend  <= 1'b0;
      end else begin
        if (w_adelDeliver) begin
          r_idInst  <= 32'd0;
          r_idPc    <= r_pc;
          r_idValid <= 1'b1;
          r_idAdel  <= 1'b1;
        end else if (!stall) begin
          r_idValid <= 1'b0;
        end
        if (br_taken) begin
          r_brPend <= 1'b1;
          r_brPc   <= br_target;
        end
      end
    end
  end

  assign ireq     = w_ireq;
  assign iaddr    = r_pc;
  assign id_inst  = r_idInst;
  assign id_pc    = r_idPc;
  assign id_valid = r_idValid;
  assign id_adel  = r_idAdel;

endmodule
